// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;
  localparam logic [5:0] FUNCT_MULT  = 6'd24;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_DIV   = 6'd26;
  localparam logic [5:0] FUNCT_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration: add-and-shift-right for multiply, or restoring
// trial-subtract-and-shift-left for divide, on the {acc, q} pair.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] m_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    sum     = {1'b0, acc_i} + {1'b0, m_i};
    shifted = {acc_i, q_i[XLEN-1]};
    trial   = shifted - {1'b0, m_i};
    acc_o   = acc_i;
    q_o     = q_i;
    if (is_div_i) begin
      // A set MSB on the trial means the subtraction borrowed: restore.
      acc_o = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      q_o   = {q_i[XLEN-2:0], ~trial[XLEN]};
    end else if (q_i[0]) begin
      {acc_o, q_o} = {sum, q_i[XLEN-1:1]};
    end else begin
      {acc_o, q_o} = {1'b0, acc_i, q_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; iterates one bit per
// cycle on operand magnitudes, then applies signs in a single fixup cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [5:0]      funct_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            hilo_read_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d, a_q, a_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d, done_q, done_d;

  logic            is_signed, is_div_op, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, step_acc, step_q;
  logic [2*XLEN-1:0] prod, prod_fix;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .q_i      (q_q),
    .m_i      (m_q),
    .acc_o    (step_acc),
    .q_o      (step_q)
  );

  always_comb begin
    is_signed = (funct_i == FUNCT_MULT) || (funct_i == FUNCT_DIV);
    is_div_op = (funct_i == FUNCT_DIV) || (funct_i == FUNCT_DIVU);
    a_neg     = is_signed & op_a_i[XLEN-1];
    b_neg     = is_signed & op_b_i[XLEN-1];
    a_mag     = a_neg ? -op_a_i : op_a_i;
    b_mag     = b_neg ? -op_b_i : op_b_i;
    prod      = {acc_q, q_q};
    prod_fix  = neg_q ? -prod : prod;

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    m_d       = m_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && is_muldiv(funct_i)) begin
          cnt_d     = '0;
          acc_d     = '0;
          a_d       = op_a_i;
          is_div_d  = is_div_op;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = is_div_op && (op_b_i == '0);
          // Multiply shifts the multiplier out of q; divide shifts the dividend.
          q_d       = is_div_op ? a_mag : b_mag;
          m_d       = is_div_op ? b_mag : a_mag;
          state_d   = (is_div_op && (op_b_i == '0)) ? FIX : ITER;
        end
      end
      ITER: begin
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else if (is_div_q) begin
          lo_d = neg_q ? -q_q : q_q;
          hi_d = neg_rem_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign stall_o = busy_o & (hilo_read_i | start_i);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed table of mul/div vectors plus hand sequences for stall and reset.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [5:0]  funct_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        hilo_read_i;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .funct_i     (funct_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .hilo_read_i (hilo_read_i),
    .busy_o      (busy_o),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          busy;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op for a single cycle, then wait (bounded) for done_o.
  // lat counts edges from the accept edge (1) to the edge after which done_o is seen.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt,
                        output logic [31:0] hi, output logic [31:0] lo);
    funct_i = f; op_a_i = a; op_b_i = b; start_i = 1'b1;
    tick();
    start_i  = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done_o && lat < 60) begin
      if (busy_o) busy_cnt++;
      tick();
      lat++;
    end
    hi = hi_o;
    lo = lo_o;
  endtask

  initial begin
    int          lat, bc, k;
    logic [31:0] hi, lo;
    logic        seen;

    vecs[0] = '{FUNCT_MULTU, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 34, 33};
    vecs[1] = '{FUNCT_MULT,  32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 33};
    vecs[2] = '{FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33};
    vecs[3] = '{FUNCT_DIVU,  32'd100,       32'd7,          32'd2,         32'd14,        34, 33};
    vecs[4] = '{FUNCT_DIVU,  32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF, 2,  1};
    vecs[5] = '{FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 34, 33};
    vecs[6] = '{FUNCT_MULT,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0,         34, 33};
    vecs[7] = '{FUNCT_DIV,   32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 34, 33};
    vecs[8] = '{FUNCT_MULTU, 32'h0001_0000, 32'h0001_0000,  32'd1,         32'd0,         34, 33};
    vecs[9] = '{FUNCT_DIV,   32'hFFFF_FFF0, 32'd0,          32'hFFFF_FFF0, 32'hFFFF_FFFF, 2,  1};

    rst = 1'b1; start_i = 1'b0; funct_i = '0; op_a_i = '0; op_b_i = '0; hilo_read_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);

    // Non-muldiv funct must be ignored; no stall while idle.
    funct_i = 6'd32; op_a_i = 32'd1; op_b_i = 32'd1; start_i = 1'b1; hilo_read_i = 1'b1;
    #1 check("idle_stall", {31'd0, stall_o}, 32'd0);
    tick();
    start_i = 1'b0; hilo_read_i = 1'b0;
    check("ignored_funct_busy", {31'd0, busy_o}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, lat, bc, hi, lo);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busycyc", i), bc, vecs[i].busy);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("vec%0d_busy_at_done", i), {31'd0, busy_o}, 32'd0);
      $display("vec%0d funct=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h lat=%0d",
               i, vecs[i].f, vecs[i].a, vecs[i].b, hi, lo, lat);
    end

    // MULT 6x7, then DIVU 9/4 and a HI/LO read arrive at cycle 5 while busy.
    funct_i = FUNCT_MULT; op_a_i = 32'd6; op_b_i = 32'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    k = 1;
    repeat (4) begin tick(); k++; end
    funct_i = FUNCT_DIVU; op_a_i = 32'd9; op_b_i = 32'd4; start_i = 1'b1; hilo_read_i = 1'b1;
    #1 check("stall_while_busy", {31'd0, stall_o}, 32'd1);
    while (!done_o && k < 60) begin tick(); k++; end
    check("mult_with_pending_lat", k, 34);
    check("mult_with_pending_hi", hi_o, 32'd0);
    check("mult_with_pending_lo", lo_o, 32'd42);
    check("stall_drop_at_done", {31'd0, stall_o}, 32'd0);
    $display("seq stall: MULT 6x7 hi=0x%08h lo=0x%08h lat=%0d", hi_o, lo_o, k);
    hilo_read_i = 1'b0;
    tick();
    start_i = 1'b0;
    check("second_op_accepted", {31'd0, busy_o}, 32'd1);
    k = 1;
    while (!done_o && k < 60) begin tick(); k++; end
    check("second_op_lat", k, 34);
    check("second_op_hi", hi_o, 32'd1);
    check("second_op_lo", lo_o, 32'd2);
    $display("seq stall: DIVU 9/4 hi=0x%08h lo=0x%08h lat=%0d", hi_o, lo_o, k);

    // Reset in the middle of a MULTU; no done pulse may follow.
    funct_i = FUNCT_MULTU; op_a_i = 32'hFFFF_FFFF; op_b_i = 32'hFFFF_FFFF; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_lo", lo_o, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done_o) seen = 1'b1;
    end
    check("midrst_no_done_pulse", {31'd0, seen}, 32'd0);
    run_op(FUNCT_MULTU, 32'd3, 32'd4, lat, bc, hi, lo);
    check("after_rst_lat", lat, 34);
    check("after_rst_hi", hi, 32'd0);
    check("after_rst_lo", lo, 32'd12);
    $display("seq reset: MULTU 3x4 hi=0x%08h lo=0x%08h lat=%0d", hi, lo, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
